// File: rtl/data_mem_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle between two requesters (A = CPU, B = loader/DMA), the arbiter and the
// shared data memory. The arbiter uses the slave view; the environment uses master.
interface data_mem_arbiter_if;
    logic        A_Req, A_Write;
    logic [31:0] A_Addr, A_WData;
    logic        A_Gnt, A_Ack, A_Err;
    logic [31:0] A_RData;

    logic        B_Req, B_Write;
    logic [31:0] B_Addr, B_WData;
    logic        B_Gnt, B_Ack, B_Err;
    logic [31:0] B_RData;

    logic [31:0] Mem_Address, Mem_WriteData;
    logic        Mem_WriteEnable, Mem_MemRead;
    logic [31:0] Mem_ReadData;

    modport slave (
        input  A_Req, A_Write, A_Addr, A_WData,
        output A_Gnt, A_Ack, A_Err, A_RData,
        input  B_Req, B_Write, B_Addr, B_WData,
        output B_Gnt, B_Ack, B_Err, B_RData,
        output Mem_Address, Mem_WriteData, Mem_WriteEnable, Mem_MemRead,
        input  Mem_ReadData
    );

    modport master (
        output A_Req, A_Write, A_Addr, A_WData,
        input  A_Gnt, A_Ack, A_Err, A_RData,
        output B_Req, B_Write, B_Addr, B_WData,
        input  B_Gnt, B_Ack, B_Err, B_RData,
        input  Mem_Address, Mem_WriteData, Mem_WriteEnable, Mem_MemRead,
        output Mem_ReadData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter in front of a synchronous single-port data memory.
// One transaction in flight: IDLE -> ACCESS -> (WAIT for reads) -> DONE -> IDLE.
module data_mem_arbiter #(
    parameter int DEPTH = 1024
) (
    input  logic              Clock,
    input  logic              Reset_n,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    state_e      state_q, state_d;
    logic        win_q, win_d;     // 0 = A, 1 = B
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic        ok_q, ok_d;       // latched address is inside the memory
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d, re_q, re_d;
    logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic        a_err_q, a_err_d, b_err_q, b_err_d;
    logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        pick, fin;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        wr_d      = wr_q;
        ok_d      = ok_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        // On a tie the port that was not served last wins; otherwise the lone requester.
        pick = (bus.A_Req && bus.B_Req) ? ~last_q : bus.B_Req;
        // Completion is flagged on the edge that enters DONE, so Ack/Err/RData land together.
        fin  = (state_q == WAIT) || (state_q == ACCESS && wr_q);

        unique case (state_q)
            IDLE: begin
                if (bus.A_Req || bus.B_Req) begin
                    win_d   = pick;
                    last_d  = pick;
                    wr_d    = pick ? bus.B_Write : bus.A_Write;
                    addr_d  = pick ? bus.B_Addr  : bus.A_Addr;
                    wdata_d = pick ? bus.B_WData : bus.A_WData;
                    ok_d    = {1'b0, addr_d} < DEPTH_W;
                    we_d    = wr_d && ok_d;
                    re_d    = !wr_d && ok_d;
                    a_gnt_d = !pick;
                    b_gnt_d = pick;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = wr_q ? DONE : WAIT;
            WAIT: begin
                if (win_q) b_rdata_d = ok_q ? bus.Mem_ReadData : 32'd0;
                else       a_rdata_d = ok_q ? bus.Mem_ReadData : 32'd0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        a_ack_d = fin && !win_q;
        b_ack_d = fin && win_q;
        a_err_d = fin && !win_q && !ok_q;
        b_err_d = fin && win_q && !ok_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            wr_q      <= 1'b0;
            ok_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            ok_q      <= ok_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // The latched request doubles as the memory bus, so it holds between accesses.
    assign bus.Mem_Address     = addr_q;
    assign bus.Mem_WriteData   = wdata_q;
    assign bus.Mem_WriteEnable = we_q;
    assign bus.Mem_MemRead     = re_q;
    assign bus.A_Gnt   = a_gnt_q;
    assign bus.B_Gnt   = b_gnt_q;
    assign bus.A_Ack   = a_ack_q;
    assign bus.B_Ack   = b_ack_q;
    assign bus.A_Err   = a_err_q;
    assign bus.B_Err   = b_err_q;
    assign bus.A_RData = a_rdata_q;
    assign bus.B_RData = b_rdata_q;
endmodule
